calendar_counter: RTL
=====================

# calendar_counter

Time-of-day and date counter driven by the one-second tick from the frequency divider. It holds seconds, minutes, hours, day of week, day of month, month and year (2000–2099), with full month-length and leap-year handling. It also accepts a synchronous time/date load from the user-setting logic. Its outputs feed the display and alarm stages.

## Interface
- No parameters; all widths and limits are fixed.
- SYS_CLK  in  1  system clock; the only clock in the block.
- SYS_RST_N  in  1  reset: synchronous, active-low, sampled on the rising edge of SYS_CLK.
- S_F  in  1  one-second tick; single-cycle pulse from the divider, never asserted on consecutive cycles.
- SET_EN  in  1  single-cycle load strobe.
- SET_SEC, SET_MIN  in  6 each  load values, 0–59.
- SET_HOUR  in  5  load value, 0–23.
- SET_DAY  in  5  load value, 1 to the month length.
- SET_MON  in  4  load value, 1–12.
- SET_YEAR  in  7  load value, 0–99, meaning 2000–2099.
- SET_WDAY  in  3  load value, 0–6, where 0 is Sunday.
- SEC, MIN  out  6 each  current second and minute.
- HOUR  out  5  current hour.
- DAY  out  5  current day of month.
- MON  out  4  current month.
- YEAR  out  7  current year offset from 2000.
- WDAY  out  3  current day of week.
- MIN_F, HOUR_F, DAY_F  out  1 each  single-cycle rollover pulses.
- SET_ERR  out  1  single-cycle pulse: a load was rejected.

## Operation
- Reset, when SYS_RST_N=0 at a clock edge:
  - Date/time becomes 2000-01-01 00:00:00, day Saturday: SEC=0, MIN=0, HOUR=0, DAY=1, MON=1, YEAR=0, WDAY=6.
  - MIN_F, HOUR_F, DAY_F and SET_ERR are all 0.
  - Reset overrides any SET_EN or S_F in the same cycle.
- Priority on each edge, highest first: reset, then load, then tick, then hold.
- Tick (S_F=1, no SET_EN): SEC increments. When SEC=59 it wraps to 0 and the carry chain runs:
  - MIN increments, wrapping 59→0.
  - HOUR increments, wrapping 23→0.
  - On the hour wrap, DAY and WDAY advance together. WDAY wraps 6→0.
  - DAY wraps from the month length to 1, and MON increments.
  - MON wraps 12→1, and YEAR increments.
  - YEAR wraps 99→0, giving 2099-12-31 → 2000-01-01.
- Month length:
  - 31 days: months 1, 3, 5, 7, 8, 10, 12.
  - 30 days: months 4, 6, 9, 11.
  - Month 2: 29 days if YEAR[1:0]==0, otherwise 28. Within 2000–2099 every year divisible by 4 is a leap year, including 2000.
- Rollover pulses:
  - MIN_F pulses on the edge where SEC wraps 59→0.
  - HOUR_F pulses where MIN wraps.
  - DAY_F pulses where HOUR wraps.
  - Each pulse is high for exactly one cycle, in the same cycle the wrapped value first appears. Pulses nest, so at midnight all three are high together.
- Load (SET_EN=1):
  - The load is valid only if every field is in range and SET_DAY does not exceed the length of SET_MON in year SET_YEAR.
  - Valid load: all seven fields load at once, SET_ERR=0, and no rollover pulses fire.
  - Invalid load: all counters hold their values and SET_ERR pulses for one cycle.
  - Either way, an S_F in the same cycle is discarded, not deferred.
- SEC=59 is used only as a wrap point. Leap seconds are not supported.

## Timing
- Every output is registered.
- Tick latency: S_F sampled high at edge N means the new values and any rollover pulses are visible after edge N, i.e. for the cycle N→N+1.
- Load latency: SET_EN at edge N means the loaded values, or the SET_ERR pulse, are visible after edge N.
- All rollover pulses and SET_ERR return to 0 on the next edge unless re-triggered.
- The whole carry chain resolves within one cycle. No field shows an intermediate value.
- Reset held low for a single edge is sufficient. Values hold steady while reset stays low.

## Test plan
- Reset then tick:
  - Stimulus: assert SYS_RST_N=0 for 1 cycle, release, then 60 S_F pulses.
  - Required: after reset, 2000-01-01 00:00:00 with WDAY=6 and all pulses 0. After the 60th tick, SEC=0, MIN=1, and MIN_F is high for exactly 1 cycle.
- Midnight and month rollover:
  - Stimulus: load 2023-04-30 23:59:59, WDAY=0, then one S_F.
  - Required: 2023-05-01 00:00:00, WDAY=1, and MIN_F, HOUR_F, DAY_F high in the same single cycle.
- Leap-year February:
  - Stimulus: load 2024-02-28 23:59:59 and tick; then load 2023-02-28 23:59:59 and tick.
  - Required: first case gives DAY=29, MON=2. Second case gives DAY=1, MON=3.
- Century wrap:
  - Stimulus: load 2099-12-31 23:59:59 (YEAR=99), WDAY=4, and tick.
  - Required: YEAR=0, MON=1, DAY=1, HOUR=0, MIN=0, SEC=0, WDAY=5.
- Invalid load:
  - Stimulus: SET_EN with SET_MON=4, SET_DAY=31; separately, with SET_HOUR=24.
  - Required: in both cases SET_ERR is high for 1 cycle and all outputs are unchanged.
- Collisions:
  - Stimulus: SET_EN and S_F in the same cycle with a valid load of 12:00:00; then SYS_RST_N=0 together with SET_EN and S_F.
  - Required: first case gives SEC=0 exactly as loaded, with the tick lost. Second case gives the reset values.

Source files
------------

// File: rtl/calendar_counter.sv
// Time-of-day and date counter (2000-2099) advanced by a one-second tick, with validated synchronous load.
// Latency: one cycle from S_F or SET_EN to registered outputs; the whole carry chain resolves in that cycle.
// Backpressure: none; every tick and every load is acted on in the cycle it arrives.
module calendar_counter (
    input  logic       SYS_CLK,
    input  logic       SYS_RST_N,
    input  logic       S_F,
    input  logic       SET_EN,
    input  logic [5:0] SET_SEC,
    input  logic [5:0] SET_MIN,
    input  logic [4:0] SET_HOUR,
    input  logic [4:0] SET_DAY,
    input  logic [3:0] SET_MON,
    input  logic [6:0] SET_YEAR,
    input  logic [2:0] SET_WDAY,
    output logic [5:0] SEC,
    output logic [5:0] MIN,
    output logic [4:0] HOUR,
    output logic [4:0] DAY,
    output logic [3:0] MON,
    output logic [6:0] YEAR,
    output logic [2:0] WDAY,
    output logic       MIN_F,
    output logic       HOUR_F,
    output logic       DAY_F,
    output logic       SET_ERR
);

    // Every year 2000-2099 divisible by 4 is a leap year, so only the low two bits matter.
    function automatic logic [4:0] month_len(input logic [3:0] mon, input logic [1:0] yr_lo);
        case (mon)
            4'd4, 4'd6, 4'd9, 4'd11: month_len = 5'd30;
            4'd2:                    month_len = (yr_lo == 2'd0) ? 5'd29 : 5'd28;
            default:                 month_len = 5'd31;
        endcase
    endfunction

    logic [4:0] cur_len;
    logic [4:0] set_len;
    logic       set_ok;
    logic       sec_wrap, min_wrap, hour_wrap, day_wrap, mon_wrap;

    always_comb begin
        cur_len = month_len(MON, YEAR[1:0]);
        set_len = month_len(SET_MON, SET_YEAR[1:0]);
        set_ok  = (SET_SEC <= 6'd59) && (SET_MIN <= 6'd59) && (SET_HOUR <= 5'd23) &&
                  (SET_MON >= 4'd1) && (SET_MON <= 4'd12) && (SET_YEAR <= 7'd99) &&
                  (SET_WDAY <= 3'd6) && (SET_DAY >= 5'd1) && (SET_DAY <= set_len);
    end

    assign sec_wrap  = (SEC == 6'd59);
    assign min_wrap  = sec_wrap  && (MIN == 6'd59);
    assign hour_wrap = min_wrap  && (HOUR == 5'd23);
    assign day_wrap  = hour_wrap && (DAY >= cur_len);
    assign mon_wrap  = day_wrap  && (MON == 4'd12);

    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST_N) begin
            SEC     <= 6'd0;
            MIN     <= 6'd0;
            HOUR    <= 5'd0;
            DAY     <= 5'd1;
            MON     <= 4'd1;
            YEAR    <= 7'd0;
            WDAY    <= 3'd6;
            MIN_F   <= 1'b0;
            HOUR_F  <= 1'b0;
            DAY_F   <= 1'b0;
            SET_ERR <= 1'b0;
        end else begin
            MIN_F   <= 1'b0;
            HOUR_F  <= 1'b0;
            DAY_F   <= 1'b0;
            SET_ERR <= 1'b0;
            // A tick arriving with a load is dropped, whether the load is accepted or not.
            if (SET_EN) begin
                if (set_ok) begin
                    SEC  <= SET_SEC;
                    MIN  <= SET_MIN;
                    HOUR <= SET_HOUR;
                    DAY  <= SET_DAY;
                    MON  <= SET_MON;
                    YEAR <= SET_YEAR;
                    WDAY <= SET_WDAY;
                end else begin
                    SET_ERR <= 1'b1;
                end
            end else if (S_F) begin
                SEC <= sec_wrap ? 6'd0 : SEC + 6'd1;
                if (sec_wrap) begin
                    MIN_F <= 1'b1;
                    MIN   <= min_wrap ? 6'd0 : MIN + 6'd1;
                end
                if (min_wrap) begin
                    HOUR_F <= 1'b1;
                    HOUR   <= hour_wrap ? 5'd0 : HOUR + 5'd1;
                end
                if (hour_wrap) begin
                    DAY_F <= 1'b1;
                    DAY   <= day_wrap ? 5'd1 : DAY + 5'd1;
                    WDAY  <= (WDAY == 3'd6) ? 3'd0 : WDAY + 3'd1;
                end
                if (day_wrap) begin
                    MON <= mon_wrap ? 4'd1 : MON + 4'd1;
                end
                if (mon_wrap) begin
                    YEAR <= (YEAR == 7'd99) ? 7'd0 : YEAR + 7'd1;
                end
            end
        end
    end

endmodule
